// File: rtl/sd_adc_pkg.sv
`default_nettype none
// ============================================================================
// Module      : sd_adc_pkg
// Description : Shared types and defaults for the sigma-delta ADC chain.
// Revision    : 1.0 - initial release
// ============================================================================
package sd_adc_pkg;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        SETTLE = 2'd1,
        RUN    = 2'd2
    } state_t;

    localparam int DEFAULT_DECIM_LOG2  = 8;
    localparam int DEFAULT_SYNC_STAGES = 2;

endpackage
`default_nettype wire

// File: rtl/sd_sync.sv
`default_nettype none
// ============================================================================
// Module      : sd_sync
// Description : N-flop single-bit synchroniser, synchronous reset to 0.
// Revision    : 1.0 - initial release
// ============================================================================
module sd_sync #(
    parameter int STAGES = 2
) (
    input  logic clk,
    input  logic rst,
    input  logic d,
    output logic q
);

    logic [STAGES-1:0] sync_q;

    always_ff @(posedge clk) begin
        if (rst) begin
            sync_q <= '0;
        end else begin
            sync_q <= {sync_q[STAGES-2:0], d};
        end
    end

    assign q = sync_q[STAGES-1];

endmodule
`default_nettype wire

// File: rtl/sd_adc_decim.sv
`default_nettype none
// ============================================================================
// Module      : sd_adc_decim
// Description : First-order sigma-delta loop closure and boxcar decimator
//               with a valid/ready sample port and sticky overrun flag.
// Revision    : 1.0 - initial release
// ============================================================================
module sd_adc_decim
    import sd_adc_pkg::*;
#(
    parameter int DECIM_LOG2  = DEFAULT_DECIM_LOG2,
    parameter int SYNC_STAGES = DEFAULT_SYNC_STAGES
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  cmp_in,
    input  logic                  en,
    output logic                  fb_out,
    output logic [DECIM_LOG2:0]   sample_data,
    output logic                  sample_valid,
    input  logic                  sample_ready,
    output logic                  overrun,
    input  logic                  clr_overrun
);

    localparam logic [DECIM_LOG2-1:0] CNT_ONE  = {{(DECIM_LOG2-1){1'b0}}, 1'b1};
    localparam logic [DECIM_LOG2:0]   ACC_ZERO = '0;

    logic                  cmp_s;
    state_t                state;
    logic [DECIM_LOG2-1:0] counter;
    logic [DECIM_LOG2:0]   acc;
    logic [DECIM_LOG2:0]   acc_next;
    logic                  terminal;

    sd_sync #(
        .STAGES (SYNC_STAGES)
    ) u_cmp_sync (
        .clk (clk),
        .rst (rst),
        .d   (cmp_in),
        .q   (cmp_s)
    );

    // Bit being applied to the DAC this cycle is the one counted.
    assign acc_next = acc + {ACC_ZERO[DECIM_LOG2:1], fb_out};
    assign terminal = &counter;

    always_ff @(posedge clk) begin
        if (rst) begin
            state        <= IDLE;
            fb_out       <= 1'b0;
            counter      <= '0;
            acc          <= '0;
            sample_data  <= '0;
            sample_valid <= 1'b0;
            overrun      <= 1'b0;
        end else begin
            fb_out <= (en && (state != IDLE)) ? cmp_s : 1'b0;

            if (clr_overrun) begin
                overrun <= 1'b0;
            end
            if (sample_valid && sample_ready) begin
                sample_valid <= 1'b0;
            end

            case (state)
                IDLE: begin
                    counter <= '0;
                    acc     <= '0;
                    if (en) begin
                        state <= SETTLE;
                    end
                end
                SETTLE: begin
                    if (!en) begin
                        state   <= IDLE;
                        counter <= '0;
                        acc     <= '0;
                    end else begin
                        counter <= counter + CNT_ONE;
                        if (terminal) begin
                            state <= RUN;
                        end
                    end
                end
                RUN: begin
                    if (!en) begin
                        state   <= IDLE;
                        counter <= '0;
                        acc     <= '0;
                    end else begin
                        counter <= counter + CNT_ONE;
                        if (terminal) begin
                            sample_data  <= acc_next;
                            acc          <= '0;
                            sample_valid <= 1'b1;
                            // New sample replacing one still unconsumed; set beats clear.
                            if (sample_valid && !sample_ready) begin
                                overrun <= 1'b1;
                            end
                        end else begin
                            acc <= acc_next;
                        end
                    end
                end
                default: begin
                    state   <= IDLE;
                    counter <= '0;
                    acc     <= '0;
                end
            endcase
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_sd_adc_decim.sv
`default_nettype none
// ============================================================================
// Module      : tb_sd_adc_decim
// Description : Directed self-checking bench for sd_adc_decim (DECIM_LOG2=4).
// Revision    : 1.0 - initial release
// ============================================================================
module tb_sd_adc_decim;

    localparam int DL = 4;
    localparam int SS = 2;

    logic          clk          = 1'b0;
    logic          rst          = 1'b1;
    logic          cmp_in       = 1'b0;
    logic          en           = 1'b0;
    logic          sample_ready = 1'b1;
    logic          clr_overrun  = 1'b0;
    logic          fb_out;
    logic          sample_valid;
    logic          overrun;
    logic [DL:0]   sample_data;

    int n_chk  = 0;
    int n_fail = 0;
    int cyc    = 0;

    sd_adc_decim #(
        .DECIM_LOG2  (DL),
        .SYNC_STAGES (SS)
    ) dut (
        .clk          (clk),
        .rst          (rst),
        .cmp_in       (cmp_in),
        .en           (en),
        .fb_out       (fb_out),
        .sample_data  (sample_data),
        .sample_valid (sample_valid),
        .sample_ready (sample_ready),
        .overrun      (overrun),
        .clr_overrun  (clr_overrun)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
        cyc++;
    endtask

    task automatic do_reset();
        rst          = 1'b1;
        en           = 1'b0;
        cmp_in       = 1'b0;
        sample_ready = 1'b1;
        clr_overrun  = 1'b0;
        repeat (3) tick();
        rst = 1'b0;
        cyc = 0;
    endtask

    task automatic test_reset();
        do_reset();
        n_chk++;
        if ({fb_out, sample_valid, overrun, sample_data} !== '0) begin
            n_fail++;
            $display("FAIL reset_outputs: got fb=%b v=%b ov=%b d=%0d, want all 0",
                     fb_out, sample_valid, overrun, sample_data);
        end
        cmp_in = 1'b1;
        repeat (40) tick();
        n_chk++;
        if ({fb_out, sample_valid} !== 2'b00) begin
            n_fail++;
            $display("FAIL idle_quiet: got fb=%b v=%b, want 0 0", fb_out, sample_valid);
        end
    endtask

    task automatic test_ones();
        do_reset();
        cmp_in = 1'b1;
        en     = 1'b1;
        for (int i = 0; i < 49; i++) begin
            tick();
            if (cyc == 2) begin
                n_chk++;
                if (fb_out !== 1'b0) begin
                    n_fail++;
                    $display("FAIL ones_fb_early: cyc=%0d got %b want 0", cyc, fb_out);
                end
            end
            if (cyc == 3) begin
                n_chk++;
                if (fb_out !== 1'b1) begin
                    n_fail++;
                    $display("FAIL ones_fb_latency: cyc=%0d got %b want 1", cyc, fb_out);
                end
            end
            if (cyc == 32) begin
                n_chk++;
                if (sample_valid !== 1'b0) begin
                    n_fail++;
                    $display("FAIL ones_settle_no_sample: got v=%b want 0", sample_valid);
                end
            end
            if (cyc == 33 || cyc == 49) begin
                n_chk++;
                if ({sample_valid, sample_data} !== {1'b1, 5'd16}) begin
                    n_fail++;
                    $display("FAIL ones_sample: cyc=%0d got v=%b d=%0d want v=1 d=16",
                             cyc, sample_valid, sample_data);
                end
            end
            if (cyc == 34) begin
                n_chk++;
                if (sample_valid !== 1'b0) begin
                    n_fail++;
                    $display("FAIL ones_accept: got v=%b want 0", sample_valid);
                end
            end
        end
    endtask

    task automatic test_zeros();
        do_reset();
        cmp_in = 1'b0;
        en     = 1'b1;
        for (int i = 0; i < 49; i++) begin
            tick();
            n_chk++;
            if (fb_out !== 1'b0) begin
                n_fail++;
                $display("FAIL zeros_fb: cyc=%0d got %b want 0", cyc, fb_out);
            end
            if (cyc == 33 || cyc == 49) begin
                n_chk++;
                if ({sample_valid, sample_data} !== {1'b1, 5'd0}) begin
                    n_fail++;
                    $display("FAIL zeros_sample: cyc=%0d got v=%b d=%0d want v=1 d=0",
                             cyc, sample_valid, sample_data);
                end
            end
        end
    endtask

    task automatic test_toggle();
        do_reset();
        en = 1'b1;
        for (int i = 0; i < 65; i++) begin
            cmp_in = ~cmp_in;
            tick();
            if (cyc == 33 || cyc == 49 || cyc == 65) begin
                n_chk++;
                if ({sample_valid, sample_data} !== {1'b1, 5'd8}) begin
                    n_fail++;
                    $display("FAIL toggle_sample: cyc=%0d got v=%b d=%0d want v=1 d=8",
                             cyc, sample_valid, sample_data);
                end
            end
        end
    endtask

    task automatic test_overrun();
        do_reset();
        cmp_in       = 1'b1;
        en           = 1'b1;
        sample_ready = 1'b0;
        repeat (33) tick();
        n_chk++;
        if ({sample_valid, overrun, sample_data} !== {2'b10, 5'd16}) begin
            n_fail++;
            $display("FAIL ovr_first: got v=%b ov=%b d=%0d want v=1 ov=0 d=16",
                     sample_valid, overrun, sample_data);
        end
        // fb_out still 1 for the first three counted cycles of the next window.
        cmp_in = 1'b0;
        while (cyc < 48) begin
            tick();
            n_chk++;
            if ({sample_valid, overrun, sample_data} !== {2'b10, 5'd16}) begin
                n_fail++;
                $display("FAIL ovr_hold: cyc=%0d got v=%b ov=%b d=%0d want v=1 ov=0 d=16",
                         cyc, sample_valid, overrun, sample_data);
            end
        end
        tick();
        n_chk++;
        if ({sample_valid, overrun, sample_data} !== {2'b11, 5'd3}) begin
            n_fail++;
            $display("FAIL ovr_set: got v=%b ov=%b d=%0d want v=1 ov=1 d=3",
                     sample_valid, overrun, sample_data);
        end
        clr_overrun = 1'b1;
        tick();
        clr_overrun = 1'b0;
        n_chk++;
        if ({sample_valid, overrun} !== 2'b10) begin
            n_fail++;
            $display("FAIL ovr_clear: got v=%b ov=%b want v=1 ov=0", sample_valid, overrun);
        end
        while (cyc < 64) tick();
        sample_ready = 1'b1;
        tick();
        n_chk++;
        if ({sample_valid, overrun, sample_data} !== {2'b10, 5'd0}) begin
            n_fail++;
            $display("FAIL accept_with_new: got v=%b ov=%b d=%0d want v=1 ov=0 d=0",
                     sample_valid, overrun, sample_data);
        end
        tick();
        n_chk++;
        if (sample_valid !== 1'b0) begin
            n_fail++;
            $display("FAIL accept_drop: got v=%b want 0", sample_valid);
        end
    endtask

    task automatic test_en_drop();
        do_reset();
        cmp_in = 1'b1;
        en     = 1'b1;
        repeat (38) tick();
        en = 1'b0;
        tick();
        n_chk++;
        if ({fb_out, sample_valid} !== 2'b00) begin
            n_fail++;
            $display("FAIL en_drop_idle: got fb=%b v=%b want 0 0", fb_out, sample_valid);
        end
        repeat (2) tick();
        en = 1'b1;
        while (cyc < 73) begin
            tick();
            n_chk++;
            if (sample_valid !== 1'b0) begin
                n_fail++;
                $display("FAIL en_resettle: cyc=%0d got v=%b want 0", cyc, sample_valid);
            end
        end
        sample_ready = 1'b0;
        tick();
        n_chk++;
        if ({sample_valid, overrun, sample_data} !== {2'b10, 5'd16}) begin
            n_fail++;
            $display("FAIL en_resume_sample: got v=%b ov=%b d=%0d want v=1 ov=0 d=16",
                     sample_valid, overrun, sample_data);
        end
    endtask

    task automatic test_reset_mid();
        do_reset();
        cmp_in       = 1'b1;
        en           = 1'b1;
        sample_ready = 1'b0;
        repeat (38) tick();
        n_chk++;
        if (sample_valid !== 1'b1) begin
            n_fail++;
            $display("FAIL rstmid_pending: got v=%b want 1", sample_valid);
        end
        rst = 1'b1;
        tick();
        rst = 1'b0;
        cyc = 0;
        n_chk++;
        if ({fb_out, sample_valid, overrun, sample_data} !== '0) begin
            n_fail++;
            $display("FAIL rstmid_outputs: got fb=%b v=%b ov=%b d=%0d want all 0",
                     fb_out, sample_valid, overrun, sample_data);
        end
        // From IDLE with en held, the first sample needs a full settle window again.
        repeat (32) tick();
        n_chk++;
        if (sample_valid !== 1'b0) begin
            n_fail++;
            $display("FAIL rstmid_settle: got v=%b want 0", sample_valid);
        end
        tick();
        n_chk++;
        if ({sample_valid, sample_data} !== {1'b1, 5'd16}) begin
            n_fail++;
            $display("FAIL rstmid_sample: got v=%b d=%0d want v=1 d=16",
                     sample_valid, sample_data);
        end
    endtask

    initial begin
        test_reset();
        test_ones();
        test_zeros();
        test_toggle();
        test_overrun();
        test_en_drop();
        test_reset_mid();
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/sd_adc_decim.md
Name: sd_adc_decim

Overview:
- Downstream consumer of the LVDS comparator bit (SB_IO D_IN_1) used as a first-order sigma-delta ADC.
- Synchronises the raw comparator bit and drives it back as the 1-bit feedback to the external RC pin.
- Counts feedback ones over a 2^DECIM_LOG2-cycle boxcar window.
- Presents each window result on a valid/ready sample port to the next stage.

Parameters:
- DECIM_LOG2, 8: window length is 2^DECIM_LOG2 clk cycles. Legal range 2..16.
- SYNC_STAGES, 2: number of synchroniser flops on cmp_in. Legal range 2..4.

Ports:
- clk  input  1: fabric clock (SB_HFOSC output).
- rst  input  1: synchronous, active-high reset.
- cmp_in  input  1: raw comparator bit from SB_IO D_IN_1, asynchronous to clk.
- en  input  1: conversion enable, level-sensitive.
- fb_out  output  1: registered feedback bit to the RC DAC pin.
- sample_data  output  DECIM_LOG2+1: ones count for the last window, 0..2^DECIM_LOG2.
- sample_valid  output  1: sample_data holds an unconsumed sample.
- sample_ready  input  1: consumer accepts the sample when high with sample_valid.
- overrun  output  1: sticky flag; a sample was overwritten before it was accepted.
- clr_overrun  input  1: clears overrun, synchronous.

Behaviour:
- Reset values: fb_out=0, sample_data=0, sample_valid=0, overrun=0, state=IDLE, synchroniser flops=0, accumulator=0, window counter=0. rst has priority over every other input on any cycle, including mid-window; the partial window is lost.
- Synchroniser: cmp_in passes through SYNC_STAGES flops to give cmp_s. Comparator-to-fb_out latency is SYNC_STAGES+1 cycles.
- fb_out: registered cmp_s in SETTLE/RUN; forced 0 in IDLE.
- Bit counted each cycle: the current fb_out value (the bit actually applied to the DAC).
- State machine:
  - IDLE: counter=0, acc=0. en=1 -> SETTLE.
  - SETTLE: runs one full window. On the terminal count (counter = 2^DECIM_LOG2-1) -> RUN. No sample is emitted.
  - RUN: each cycle counter+=1 (wraps naturally) and acc+=fb_out. On the terminal count: sample_data <= acc+fb_out (full window of exactly 2^DECIM_LOG2 bits), acc <= 0, sample_valid <= 1.
  - en=0 in SETTLE or RUN -> IDLE on the next edge. acc and counter are cleared; any pending sample and its sample_valid are kept.
- Arithmetic: acc is DECIM_LOG2+1 bits and never overflows; max = 2^DECIM_LOG2.
- Handshake:
  - sample_valid && sample_ready on an edge -> sample_valid falls next cycle, unless a new sample is produced on the same edge; in that case sample_valid stays 1 with the new data.
  - sample_data is stable while sample_valid=1 and not accepted.
- Overrun:
  - A terminal count in RUN while sample_valid=1 and sample_ready=0 overwrites sample_data with the new value and sets overrun.
  - clr_overrun=1 clears overrun. If clear and set occur on the same edge, set wins.
- No combinational path from any input to any output.

Decomposition:
- Shared package (sd_adc_pkg): state enum {IDLE, SETTLE, RUN}; default DECIM_LOG2 and SYNC_STAGES constants for reuse by later filter stages.
- One natural sub-module: sd_sync (parameterised N-flop bit synchroniser, reset to 0), instantiated once for cmp_in.

Test Plan (DECIM_LOG2=4, SYNC_STAGES=2, sample_ready=1 unless stated):
- cmp_in=1 constantly, en raised at t0 -> fb_out=1 from t0+3. First sample_valid pulse appears 32 cycles after entering SETTLE with sample_data=16, then one valid pulse with 16 every 16 cycles.
- cmp_in=0 constantly -> every sample_data=0 and fb_out stays 0.
- cmp_in toggling every cycle -> every sample_data=8.
- sample_ready=0 across two windows -> sample_valid held and data stable for the first window, overrun=1 after the second terminal count with the new value. clr_overrun pulse -> overrun=0.
- en dropped 5 cycles into a RUN window, then re-raised -> IDLE with fb_out=0 next cycle, no sample from the partial window, a full SETTLE window again before the next sample.
- rst asserted mid-window with sample_valid=1 -> next cycle all outputs are at reset values and state=IDLE.
